// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle load/store unit between the execute stage and a valid/ready memory bus
// Ports: clk/resetn (sync, active-high reset); req_* accepts one load/store when req_ready;
// mem_* drives an aligned bus access with byte strobes and lane-shifted store data;
// resp_* pulses once per request with extended load data or an error code
// (1 misaligned, 2 illegal funct3, 3 bus timeout).
module riscv_lsu #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 32,
   parameter int TIMEOUT       = 16,
   parameter int MISALIGN_TRAP = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic [1:0]          resp_code,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   state_t              state_q;
   logic                we_q, mem_valid_q, resp_valid_q, resp_err_q;
   logic [2:0]          f3_q;
   logic [OW-1:0]       off_q;
   logic [CW-1:0]       cnt_q;
   logic [1:0]          resp_code_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q, resp_rdata_q;
   logic [NB-1:0]       mem_wstrb_q;
   logic [1:0]          sz;
   logic [OW-1:0]       mask, off, aoff;
   logic                illegal, misal;
   logic [NB-1:0]       strb;
   logic [DATA_W-1:0]   wsh, t, ext;
   logic signed [DATA_W-1:0] ts;
   logic [6:0]          k;
   assign req_ready  = (state_q == IDLE) && !resetn;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign resp_code  = resp_code_q;
   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;
   // request decode; aoff is the lane offset rounded down to the access size
   always_comb begin
      sz      = req_funct3[1:0];
      mask    = OW'((1 << sz) - 1);
      off     = req_addr[OW-1:0];
      aoff    = off & ~mask;
      misal   = (off & mask) != '0;
      illegal = (DATA_W == 32 && sz == 2'd3) || (req_we && req_funct3[2]) ||
                (!req_we && req_funct3 == (DATA_W == 64 ? 3'd7 : 3'd6));
      strb    = NB'((1 << (1 << sz)) - 1) << aoff;
      wsh     = req_wdata << {aoff, 3'b000};
   end
   // load extraction: move the addressed field to the top, then shift back down
   // logically (zero-extend) or arithmetically (sign-extend)
   always_comb begin
      k   = 7'(DATA_W - (8 << f3_q[1:0]));
      t   = (mem_rdata >> {off_q, 3'b000}) << k;
      ts  = $signed(t) >>> k;
      ext = f3_q[2] ? t >> k : $unsigned(ts);
   end
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= '0;
         off_q        <= '0;
         cnt_q        <= '0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_code_q  <= '0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               we_q  <= req_we;
               f3_q  <= req_funct3;
               off_q <= aoff;
               cnt_q <= '0;
               if (illegal || (MISALIGN_TRAP != 0 && misal)) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_code_q  <= illegal ? 2'd2 : 2'd1;
                  resp_rdata_q <= '0;
               end else begin
                  state_q     <= BUS;
                  mem_valid_q <= 1'b1;
                  mem_addr_q  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                  mem_wstrb_q <= req_we ? strb : '0;
                  mem_wdata_q <= req_we ? wsh : '0;
               end
            end
            BUS: if (mem_ready) begin
               mem_valid_q  <= 1'b0;
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_code_q  <= 2'd0;
               resp_rdata_q <= we_q ? '0 : ext;
            end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
               mem_valid_q  <= 1'b0;
               mem_wstrb_q  <= '0;
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b1;
               resp_code_q  <= 2'd3;
               resp_rdata_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            default: begin
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Parametrised multi-cycle load/store unit between the RV core's execute stage and the native valid/ready memory bus; generalises the core's fixed 32-bit inline byte/half/word handling.
- Accepts one request at a time and generates an aligned bus address, byte strobes and a lane-shifted write word.
- Waits any number of memory wait states, then extracts and sign- or zero-extends load data.
- Reports misalignment, illegal funct3 and bus timeout as errors instead of silently corrupting data.

Parameters:
- DATA_W, 32, bus/register width; legal values 32 or 64; 64 enables LD/SD/LWU.
- ADDR_W, 32, address width.
- TIMEOUT, 16, maximum bus cycles waiting for mem_ready; 0 disables the timeout.
- MISALIGN_TRAP, 1, 1 = misaligned access returns an error; 0 = the address is force-aligned down and the access proceeds.

Ports:
- clk, in, 1, single clock; all state changes on its rising edge.
- resetn, in, 1, synchronous reset, active-high (the name is historical; asserted = 1).
- req_valid, in, 1, request present.
- req_ready, out, 1, unit idle and able to accept.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, RISC-V funct3 (size in [1:0]; unsigned flag in [2]).
- req_addr, in, ADDR_W, effective byte address.
- req_wdata, in, DATA_W, store data, right-justified.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, DATA_W, extended load data; 0 for stores and errors.
- resp_err, out, 1, completion carries an error.
- resp_code, out, 2, error code: 0 none, 1 misaligned, 2 illegal funct3, 3 timeout.
- mem_valid, out, 1, bus request.
- mem_ready, in, 1, bus completion.
- mem_addr, out, ADDR_W, aligned bus address.
- mem_wdata, out, DATA_W, lane-shifted store data.
- mem_wstrb, out, DATA_W/8, byte strobes; all 0 for loads.
- mem_rdata, in, DATA_W, bus read data.

Behaviour:
- Reset (resetn=1 at an edge):
  - State goes to IDLE; mem_valid, resp_valid and resp_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, resp_rdata, resp_code and the wait counter = 0.
  - Reset overrides everything. A transaction in flight is abandoned and mem_valid drops on that edge. A mem_ready arriving on the reset edge is ignored.
- req_ready = (state==IDLE) && !resetn. This is combinational from state; there is no dependency on req_valid.
- The request is accepted on an edge where req_valid && req_ready; all req_* inputs are sampled only then.
- Size decode: bytes = 1 << funct3[1:0]. The offset is req_addr modulo (DATA_W/8).
- Illegal funct3 (code 2):
  - funct3[1:0]==3 when DATA_W=32.
  - Stores with funct3[2]=1.
  - Loads with funct3==7 when DATA_W=64, and funct3==6 when DATA_W=32.
- Misaligned: req_addr modulo bytes != 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - On accept with an illegal funct3, or a misaligned access with MISALIGN_TRAP=1: go to RESP with resp_err=1 and the matching code. No bus cycle is issued. Illegal funct3 takes priority over misaligned.
  - Otherwise go to BUS and register:
    - mem_addr = req_addr with its low log2(DATA_W/8) bits cleared.
    - For stores: mem_wstrb = ((1<<bytes)-1) << offset and mem_wdata = req_wdata << (8*offset).
    - For loads: mem_wstrb = 0 and mem_wdata = 0.
    - mem_valid = 1 and the wait counter = 0.
  - With MISALIGN_TRAP=0, the offset is first rounded down to a multiple of bytes.
- BUS:
  - mem_valid and all mem_* outputs are held stable.
  - Each edge without mem_ready increments the counter.
  - mem_ready=1 at an edge: mem_valid<=0 and go to RESP. For loads, resp_rdata <= extract(mem_rdata >> 8*offset, bytes), sign-extended if funct3[2]=0 and zero-extended otherwise. resp_err=0.
  - If TIMEOUT!=0 and the counter == TIMEOUT-1 at an edge without mem_ready: mem_valid<=0, mem_wstrb<=0, resp_err=1, code 3, go to RESP. mem_ready on that same edge wins over the timeout.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata, resp_err and resp_code keep their values until the next completion.
  - There is no response backpressure.
- Latency, counting from the accept edge:
  - Error completion: resp_valid in the cycle after the accept edge.
  - Zero-wait bus (mem_ready high in the first BUS cycle): resp_valid in the 2nd cycle after accept.
  - Each wait state adds one cycle.
- mem_ready outside BUS is ignored.
- The unit never issues back-to-back bus cycles; mem_valid is low for at least two cycles between transactions.

Test Plan:
1. DATA_W=32, store SB, addr 0x1003, wdata 0x000000A5 -> mem_addr 0x1000, mem_wstrb 4'b1000, mem_wdata 0xA5000000; resp_valid 2 cycles after accept with mem_ready immediate; resp_err 0.
2. Load LH addr 0x2002, mem_rdata 0x8001_1234 -> resp_rdata 0xFFFF8001. Repeat as LHU -> 0x00008001. Load LB addr 0x2001 -> 0x00000012. mem_wstrb 0 throughout.
3. LW addr 0x3002, MISALIGN_TRAP=1 -> mem_valid never asserted; resp_valid the cycle after accept, resp_err 1, resp_code 1. funct3=3 on DATA_W=32 -> resp_code 2.
4. TIMEOUT=8, mem_ready held 0 -> mem_valid high exactly 8 cycles then low; resp_err 1, code 3. Repeat with mem_ready asserted on the 8th cycle -> normal completion, resp_err 0.
5. DATA_W=64: SD at 0x10 -> mem_wstrb 8'hFF. LW at 0x14 with mem_rdata 0x80000000_00000000 -> 0xFFFFFFFF80000000. LWU -> 0x0000000080000000.
6. resetn=1 during BUS, with 3 wait states elapsed -> mem_valid 0 next edge, no resp_valid, req_ready 1 after release; a new request then completes normally.
